// File: rtl/r2c_pkg.sv
// r2c_pkg: shared widths, derived sizes and types for the redundant-to-canonical converter.
package r2c_pkg;
    localparam int NUM_ELEMENTS = 66;
    localparam int BIT_LEN      = 17;
    localparam int WORD_LEN     = 16;
    localparam int LANES        = 2;
    localparam int CARRY_LEN    = BIT_LEN - WORD_LEN + 1;
    localparam int NUM_BEATS    = NUM_ELEMENTS / LANES;
    typedef logic [BIT_LEN-1:0]   coef_t;
    typedef logic [WORD_LEN-1:0]  word_t;
    typedef logic [CARRY_LEN-1:0] carry_t;
    typedef enum logic {IDLE, EMIT} state_t;
endpackage

// File: rtl/carry_resolve_lane.sv
// carry_resolve_lane: adds the incoming carry to one redundant coefficient and splits off the canonical word.
module carry_resolve_lane #(
    parameter int BIT_LEN   = r2c_pkg::BIT_LEN,
    parameter int WORD_LEN  = r2c_pkg::WORD_LEN,
    localparam int CARRY_LEN = BIT_LEN - WORD_LEN + 1
) (
    input  logic [BIT_LEN-1:0]   coef_i,
    input  logic [CARRY_LEN-1:0] carry_i,
    output logic [WORD_LEN-1:0]  word_o,
    output logic [CARRY_LEN-1:0] carry_o
);
    logic [BIT_LEN:0] s;
    assign s       = {1'b0, coef_i} + (BIT_LEN+1)'(carry_i);
    assign word_o  = s[WORD_LEN-1:0];
    assign carry_o = s[BIT_LEN:WORD_LEN];
endmodule

// File: rtl/redundant_to_canonical.sv
// redundant_to_canonical: streams a redundant squarer result out as canonical words, LANES per beat.
// Optional out_zero frame flag enabled by defining R2C_ZERO_FLAG_EN.
module redundant_to_canonical import r2c_pkg::*; #(
    parameter int NUM_ELEMENTS = r2c_pkg::NUM_ELEMENTS,
    parameter int BIT_LEN      = r2c_pkg::BIT_LEN,
    parameter int WORD_LEN     = r2c_pkg::WORD_LEN,
    parameter int LANES        = r2c_pkg::LANES,
    localparam int CARRY_LEN   = BIT_LEN - WORD_LEN + 1,
    localparam int NUM_BEATS   = NUM_ELEMENTS / LANES
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [BIT_LEN-1:0]        in_coef [NUM_ELEMENTS],
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WORD_LEN*LANES-1:0] out_word,
    output logic                      out_last,
    output logic [CARRY_LEN-1:0]      out_carry
`ifdef R2C_ZERO_FLAG_EN
    ,
    output logic                      out_zero
`endif
);
    localparam int BW = $clog2(NUM_BEATS + 1);
    localparam int IW = $clog2(NUM_ELEMENTS + LANES);
    state_t state_q, state_d;
    logic [BIT_LEN-1:0]        buf_q [NUM_ELEMENTS];
    logic [CARRY_LEN-1:0]      carry_q, out_carry_q;
    logic [BW-1:0]             beat_q, nb;
    logic [WORD_LEN*LANES-1:0] out_word_q, res_word;
    logic                      out_valid_q, out_last_q, hs, acc, last_d;
    logic [BIT_LEN-1:0]        src [LANES];
    logic [CARRY_LEN-1:0]      c [LANES+1];

    assign hs     = in_ready && in_valid;
    assign acc    = out_valid_q && out_ready;
    assign nb     = hs ? '0 : BW'(beat_q + 1'b1);
    assign last_d = nb == BW'(NUM_BEATS - 1);
    assign c[0]   = hs ? '0 : carry_q;

    // Beat 0 resolves straight from in_coef so it is ready one cycle after the handshake.
    for (genvar j = 0; j < LANES; j++) begin : g_lane
        logic [IW-1:0] idx;
        assign idx    = IW'(nb) * IW'(LANES) + IW'(j);
        assign src[j] = hs ? in_coef[j] : (idx < IW'(NUM_ELEMENTS) ? buf_q[idx] : '0);
        carry_resolve_lane #(.BIT_LEN(BIT_LEN), .WORD_LEN(WORD_LEN)) u_lane (
            .coef_i (src[j]),
            .carry_i(c[j]),
            .word_o (res_word[j*WORD_LEN +: WORD_LEN]),
            .carry_o(c[j+1])
        );
    end

    always_ff @(posedge clk)
        state_q <= reset ? IDLE : state_d;

    always_comb begin
        state_d = state_q;
        if (state_q == IDLE && hs) state_d = EMIT;
        if (state_q == EMIT && acc && out_last_q) state_d = IDLE;
    end

    always_comb in_ready = state_q == IDLE && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_word_q  <= '0;
            out_carry_q <= '0;
            carry_q     <= '0;
            beat_q      <= '0;
        end else if (hs || (acc && !out_last_q)) begin
            if (hs) buf_q <= in_coef;
            out_valid_q <= 1'b1;
            out_word_q  <= res_word;
            out_last_q  <= last_d;
            out_carry_q <= last_d ? c[LANES] : '0;
            carry_q     <= c[LANES];
            beat_q      <= nb;
        end else if (acc) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_carry_q <= '0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_word  = out_word_q;
    assign out_last  = out_last_q;
    assign out_carry = out_carry_q;

`ifdef R2C_ZERO_FLAG_EN
    logic nz_q;
    always_ff @(posedge clk)
        nz_q <= (reset || hs) ? 1'b0 : nz_q | (acc && (|out_word_q || |out_carry_q));
    assign out_zero = !(nz_q || |out_word_q || |out_carry_q);
`endif
endmodule

// File: tb/tb_redundant_to_canonical.sv
// tb_redundant_to_canonical: directed checks of conversion, latency, backpressure, busy-ignore and mid-frame reset.
module tb_redundant_to_canonical;
    import r2c_pkg::*;
    logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
    logic in_ready, out_valid, out_last;
    coef_t coef [NUM_ELEMENTS];
    logic [WORD_LEN*LANES-1:0] out_word;
    carry_t out_carry;
    int checks = 0, fails = 0;
`ifdef R2C_ZERO_FLAG_EN
    logic out_zero;
`endif

    redundant_to_canonical dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_coef(coef),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word), .out_last(out_last),
        .out_carry(out_carry)
`ifdef R2C_ZERO_FLAG_EN
        , .out_zero(out_zero)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // kind 0: all zero, kind 1: only coef[0]=0x1FFFF, kind 2: every coef 0x1FFFF
    task automatic fill(input int kind);
        for (int k = 0; k < NUM_ELEMENTS; k++)
            coef[k] = kind == 0 ? 17'h0 : (kind == 1 ? (k == 0 ? 17'h1FFFF : 17'h0) : 17'h1FFFF);
    endtask

    function automatic logic [31:0] exp_word(input int kind, input int b);
        if (kind == 0) return 32'h0;
        if (kind == 1) return b == 0 ? 32'h0001_FFFF : 32'h0;
        return b == 0 ? 32'h0000_FFFF : 32'h0001_0001;
    endfunction

    task automatic start(input int kind, input bit keep);
        fill(kind);
        in_valid = 1'b1;
        check("in_ready_idle", 64'(in_ready), 64'd1);
        tick();
        in_valid = keep;
        if (keep) fill(0);
        check("first_beat_latency", 64'(out_valid), 64'd1);
    endtask

    task automatic collect(input int kind, input bit stall, input bit busy_in, input int nmax);
        logic [3:0] pat = 4'b1001;
        logic [31:0] hold_w = '0;
        logic hold_l = 1'b0, hold_v = 1'b0;
        int beat = 0, cyc = 0;
        while (beat < nmax && cyc < 400) begin
            out_ready = stall ? pat[cyc % 4] : 1'b1;
            if (busy_in) check("busy_in_ready", 64'(in_ready), 64'd0);
            if (hold_v) begin
                check("stall_word_hold", 64'(out_word), 64'(hold_w));
                check("stall_last_hold", 64'(out_last), 64'(hold_l));
            end
            hold_v = 1'b0;
            if (out_valid && out_ready) begin
                check($sformatf("word_b%0d", beat), 64'(out_word), 64'(exp_word(kind, beat)));
                check($sformatf("last_b%0d", beat), 64'(out_last), 64'(beat == NUM_BEATS - 1));
                check($sformatf("carry_b%0d", beat), 64'(out_carry),
                      64'((beat == NUM_BEATS - 1 && kind == 2) ? 2 : 0));
`ifdef R2C_ZERO_FLAG_EN
                if (beat == NUM_BEATS - 1) check("zero_flag", 64'(out_zero), 64'(kind == 0));
`endif
                beat++;
            end else if (out_valid) begin
                hold_v = 1'b1;
                hold_w = out_word;
                hold_l = out_last;
            end
            tick();
            cyc++;
        end
        out_ready = 1'b1;
        check("beats_accepted", 64'(beat), 64'(nmax));
        if (nmax == NUM_BEATS) begin
            check("idle_out_valid", 64'(out_valid), 64'd0);
            check("idle_in_ready", 64'(in_ready), 64'd1);
        end
    endtask

    initial begin
        fill(0);
        tick();
        tick();
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_out_word", 64'(out_word), 64'd0);
        check("rst_out_carry", 64'(out_carry), 64'd0);
        reset = 1'b0;
        tick();
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        start(0, 1'b0); collect(0, 1'b0, 1'b0, NUM_BEATS);
        start(1, 1'b0); collect(1, 1'b0, 1'b0, NUM_BEATS);
        start(2, 1'b0); collect(2, 1'b0, 1'b0, NUM_BEATS);
        start(2, 1'b0); collect(2, 1'b1, 1'b0, NUM_BEATS);

        // in_valid held with a zero frame while the all-ones frame drains
        start(2, 1'b1); collect(2, 1'b0, 1'b1, NUM_BEATS);
        tick();
        in_valid = 1'b0;
        check("second_frame_valid", 64'(out_valid), 64'd1);
        collect(0, 1'b0, 1'b0, NUM_BEATS);

        start(2, 1'b0); collect(2, 1'b0, 1'b0, 10);
        reset = 1'b1;
        tick();
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_out_last", 64'(out_last), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd0);
        reset = 1'b0;
        tick();
        check("abort_recover_in_ready", 64'(in_ready), 64'd1);
        check("abort_recover_out_valid", 64'(out_valid), 64'd0);
        start(0, 1'b0); collect(0, 1'b0, 1'b0, NUM_BEATS);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/redundant_to_canonical.md
Name: redundant_to_canonical

Overview:
- Consumes a redundant-form result from the modular squarer: NUM_ELEMENTS coefficients of BIT_LEN bits, coefficient k weighted 2^(WORD_LEN*k).
- Resolves the inter-coefficient carries sequentially, LANES coefficients per beat.
- Streams canonical WORD_LEN-bit words out, least-significant first, with valid/ready backpressure.
- Sits between the squarer loopback output and the host/readback path.

Parameters:
- NUM_ELEMENTS, 66, number of redundant input coefficients; must be divisible by LANES.
- BIT_LEN, 17, width of each redundant coefficient.
- WORD_LEN, 16, width of each canonical output word; BIT_LEN > WORD_LEN.
- LANES, 2, coefficients resolved and words emitted per beat.
- CARRY_LEN, BIT_LEN-WORD_LEN+1, width of the inter-word carry register (derived).
- NUM_BEATS, NUM_ELEMENTS/LANES, output beats per frame (derived).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  redundant frame present on in_coef.
- in_ready  output  1  block can accept a frame.
- in_coef  input  BIT_LEN x NUM_ELEMENTS (unpacked array)  redundant coefficients, index 0 least significant.
- out_valid  output  1  out_word holds a valid beat.
- out_ready  input  1  downstream accepts the beat.
- out_word  output  WORD_LEN*LANES  canonical words; lane 0 in the LSBs.
- out_last  output  1  final beat of the frame.
- out_carry  output  CARRY_LEN  carry out of the top coefficient; valid only with out_last.

Behaviour:
- Reset values: in_ready=0 during reset and 1 in the first cycle after; out_valid=0, out_last=0, out_word=0, out_carry=0. Carry register cleared, beat counter cleared, state IDLE.
- States:
  - IDLE: in_ready=1. On in_valid, capture in_coef into a frame buffer, clear carry, beat=0, go to EMIT.
  - EMIT: in_ready=0.
- First beat latency: out_valid rises the cycle after the input handshake. Output registers load combinationally resolved beat 0 at the handshake edge.
- Lane resolve (lane j of beat b, coefficient k=b*LANES+j):
  - s = coef[k] + carry_in (width BIT_LEN+1).
  - word = s[WORD_LEN-1:0].
  - carry_out = s >> WORD_LEN, fits in CARRY_LEN bits.
  - Lanes chain combinationally within a beat.
- Beat advance: on out_valid && out_ready, store lane LANES-1's carry, increment beat, and register the next beat's words.
- Backpressure: while out_valid && !out_ready, out_word, out_last and out_carry hold stable; carry and beat do not change.
- Last beat: out_last=1 when beat==NUM_BEATS-1, and out_carry = final carry_out. Acceptance of that beat returns the block to IDLE, with out_valid=0 the next cycle.
- Throughput: one frame per NUM_BEATS+1 cycles minimum, one bubble in IDLE.
- in_valid while in EMIT is ignored; in_ready stays 0 and the buffer is untouched.
- Reset mid-frame aborts immediately; the partial frame is discarded and no out_last is produced.
- out_carry is zero on non-last beats.

Optional Feature:
- Macro R2C_ZERO_FLAG_EN.
- When defined:
  - Extra output port out_zero (1 bit), valid with out_last.
  - out_zero = 1 iff every word emitted in the frame and out_carry are all zero.
  - Built from a sticky OR accumulated on each accepted beat; cleared at the input handshake and on reset.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package r2c_pkg:
  - typedefs coef_t (logic [BIT_LEN-1:0]), word_t (logic [WORD_LEN-1:0]), carry_t (logic [CARRY_LEN-1:0]).
  - Default constants NUM_ELEMENTS, BIT_LEN, WORD_LEN, LANES.
  - CARRY_LEN/NUM_BEATS derivations.
- One sub-module, carry_resolve_lane: combinational (coef_t, carry_t in) -> (word_t, carry_t out), instantiated LANES times in a chain.
- FSM, counter, buffer and output registers stay in the top level.

Test Plan:
- All-zero frame, out_ready=1 -> 33 beats of out_word=0x00000000; out_last only on beat 32; out_carry=0; out_valid one cycle after the handshake.
- coef[0]=0x1FFFF, rest 0 -> beat 0 = {0x0001,0xFFFF} (lane1,lane0); all later beats 0; out_carry=0.
- All coefficients 0x1FFFF:
  - beat 0 = {0x0000,0xFFFF}.
  - beats 1..32 = {0x0001,0x0001}.
  - out_carry=2 on the last beat.
- Backpressure: same frame, out_ready toggled 1,0,0,1 repeating -> words identical to the unstalled run; out_word/out_last stable during stalls; frame completes with exactly 33 accepted beats.
- in_valid held high through EMIT with a different in_coef -> in_ready=0 throughout, output unchanged; the second frame is accepted only in the IDLE cycle after the last beat.
- Reset asserted at beat 10 -> next cycle out_valid=0 and no out_last; after reset deassertion in_ready=1; a fresh all-zero frame then converts correctly with out_carry=0.
